// File: rtl/flash_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : flash_arb_pkg
// Description : Shared types and constants for the flash_reader arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package flash_arb_pkg;

  localparam int FLASH_ADDR_W = 24;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_NEXT  = 2'd3
  } flash_arb_state_e;

  // Requester identifier: 0 = instruction fetch, 1 = data load
  typedef logic master_id_t;

endpackage
`default_nettype wire

// File: rtl/flash_arb_rr.sv
`default_nettype none
// ============================================================================
// Module      : flash_arb_rr
// Description : Two-way round-robin picker. A sole requester wins; on a tie
//               the master that was not granted last wins.
// Revision    : 1.0 - initial release
// ============================================================================
module flash_arb_rr
  import flash_arb_pkg::*;
(
  input  logic       i_v0,
  input  logic       i_v1,
  input  master_id_t i_last,
  output logic       o_gnt_valid,
  output master_id_t o_gnt_id
);

  // Winner selection with alternating priority on a tie
  always_comb begin
    o_gnt_valid = i_v0 | i_v1;
    o_gnt_id    = master_id_t'(1'b0);
    if (i_v0 && i_v1) begin
      o_gnt_id = ~i_last;
    end else if (i_v1) begin
      o_gnt_id = master_id_t'(1'b1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/flash_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : flash_arbiter
// Description : Shares one flash_reader byte-stream port between instruction
//               fetch (m0) and data load (m1). Round-robin grant, burst
//               sequencing over read_from_addr/read_next/data_ready, and a
//               watchdog against a stalled flash.
// Options     : FLASH_ARB_STREAM_EN - continue a contiguous stream with
//               read_next instead of re-issuing the address.
// Revision    : 1.0 - initial release
// ============================================================================
module flash_arbiter
  import flash_arb_pkg::*;
#(
  parameter int LEN_W   = 8,
  parameter int TIMEOUT = 4096
)(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    m0_req_valid,
  input  logic [FLASH_ADDR_W-1:0] m0_req_addr,
  input  logic [LEN_W-1:0]        m0_req_len,
  output logic                    m0_req_ready,
  output logic                    m0_rsp_valid,
  output logic [7:0]              m0_rsp_data,
  output logic                    m0_rsp_last,
  output logic                    m0_rsp_err,
  input  logic                    m1_req_valid,
  input  logic [FLASH_ADDR_W-1:0] m1_req_addr,
  input  logic [LEN_W-1:0]        m1_req_len,
  output logic                    m1_req_ready,
  output logic                    m1_rsp_valid,
  output logic [7:0]              m1_rsp_data,
  output logic                    m1_rsp_last,
  output logic                    m1_rsp_err,
  output logic [FLASH_ADDR_W-1:0] fr_addr,
  output logic                    fr_read_from_addr,
  output logic                    fr_read_next,
  input  logic                    fr_data_ready,
  input  logic [7:0]              fr_data
);

  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  flash_arb_state_e        r_state;
  flash_arb_state_e        w_state_nxt;
  master_id_t              r_grant;
  logic [FLASH_ADDR_W-1:0] r_cur_addr;
  logic [LEN_W-1:0]        r_remaining;
  logic                    r_dr_prev;
  logic [7:0]              r_rsp_data;
  logic [1:0]              r_rsp_valid;
  logic                    r_rsp_last;

  logic       w_gnt_valid;
  master_id_t w_gnt_id;
  logic       w_edge;
  logic       w_timeout;
  logic       w_use_next;
  logic       w_accept;
  logic       w_rd_from;
  logic       w_rd_next;
  logic       w_err;
  logic       w_byte;
  logic       w_last_byte;

  flash_arb_rr u_rr (
    .i_v0        (m0_req_valid),
    .i_v1        (m1_req_valid),
    .i_last      (r_grant),
    .o_gnt_valid (w_gnt_valid),
    .o_gnt_id    (w_gnt_id)
  );

  // A byte is signalled only by the 0->1 transition of data_ready
  assign w_edge = fr_data_ready & ~r_dr_prev;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state and handshake pulse decode
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_rd_from   = 1'b0;
    w_rd_next   = 1'b0;
    w_err       = 1'b0;
    w_byte      = 1'b0;
    w_last_byte = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_gnt_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (w_use_next) w_rd_next = 1'b1;
        else            w_rd_from = 1'b1;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        // A byte arriving on the deadline cycle still counts as delivered
        if (w_edge) begin
          w_byte = 1'b1;
          if (r_remaining == '0) begin
            w_last_byte = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_NEXT;
          end
        end else if (w_timeout) begin
          // Abort and re-point the reader so its stream position is known
          w_err       = 1'b1;
          w_rd_from   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_NEXT: begin
        w_rd_next   = 1'b1;
        w_state_nxt = ST_WAIT;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Grant/burst bookkeeping and registered byte return
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_grant     <= master_id_t'(1'b1);
      r_cur_addr  <= '0;
      r_remaining <= '0;
      r_dr_prev   <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_valid <= '0;
      r_rsp_last  <= 1'b0;
    end else begin
      r_dr_prev   <= fr_data_ready;
      r_rsp_valid <= '0;
      r_rsp_last  <= 1'b0;
      if (w_accept) begin
        r_grant     <= w_gnt_id;
        r_cur_addr  <= w_gnt_id ? m1_req_addr : m0_req_addr;
        r_remaining <= w_gnt_id ? m1_req_len  : m0_req_len;
      end
      if (w_byte) begin
        r_rsp_data           <= fr_data;
        r_rsp_valid[r_grant] <= 1'b1;
        r_rsp_last           <= w_last_byte;
        if (!w_last_byte) r_remaining <= r_remaining - LEN_W'(1);
      end
    end
  end

  generate
    if (TIMEOUT > 0) begin : g_wd
      logic [WD_W-1:0] r_wd_cnt;

      // Cycles spent waiting for the current byte; restarts on every read pulse
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)                   r_wd_cnt <= '0;
        else if (r_state == ST_WAIT) r_wd_cnt <= r_wd_cnt + WD_W'(1);
        else                        r_wd_cnt <= '0;
      end

      assign w_timeout = (r_state == ST_WAIT) && (r_wd_cnt == WD_W'(TIMEOUT));
    end else begin : g_no_wd
      assign w_timeout = 1'b0;
    end
  endgenerate

`ifdef FLASH_ARB_STREAM_EN
  logic [FLASH_ADDR_W-1:0] r_next_addr;
  logic                    r_stream_valid;
  logic [LEN_W-1:0]        r_len;

  // Track where the reader's stream will be after a completed burst
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_next_addr    <= '0;
      r_stream_valid <= 1'b0;
      r_len          <= '0;
    end else begin
      if (w_accept) r_len <= w_gnt_id ? m1_req_len : m0_req_len;
      if (w_last_byte) begin
        r_next_addr    <= r_cur_addr + FLASH_ADDR_W'(r_len) + FLASH_ADDR_W'(1);
        r_stream_valid <= 1'b1;
      end else if (w_err) begin
        r_stream_valid <= 1'b0;
      end
    end
  end

  assign w_use_next = r_stream_valid && (r_cur_addr == r_next_addr);
`else
  assign w_use_next = 1'b0;
`endif

  // Accept is gated by reset so every output is quiet while reset is held
  assign m0_req_ready = w_accept & rst & (w_gnt_id == master_id_t'(1'b0));
  assign m1_req_ready = w_accept & rst & (w_gnt_id == master_id_t'(1'b1));

  assign m0_rsp_valid = r_rsp_valid[0];
  assign m1_rsp_valid = r_rsp_valid[1];
  assign m0_rsp_data  = r_rsp_valid[0] ? r_rsp_data : 8'h00;
  assign m1_rsp_data  = r_rsp_valid[1] ? r_rsp_data : 8'h00;
  assign m0_rsp_last  = r_rsp_valid[0] & r_rsp_last;
  assign m1_rsp_last  = r_rsp_valid[1] & r_rsp_last;
  assign m0_rsp_err   = w_err & (r_grant == master_id_t'(1'b0));
  assign m1_rsp_err   = w_err & (r_grant == master_id_t'(1'b1));

  assign fr_addr           = r_cur_addr;
  assign fr_read_from_addr = w_rd_from;
  assign fr_read_next      = w_rd_next;

endmodule
`default_nettype wire

// File: tb/tb_flash_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_flash_arbiter
// Description : Scoreboard bench for flash_arbiter with a behavioural
//               flash_reader whose bytes are addr[7:0] ^ 8'hA5.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_flash_arbiter;

  localparam int LEN_W   = 8;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        m0_req_valid = 1'b0, m1_req_valid = 1'b0;
  logic [23:0] m0_req_addr = '0,    m1_req_addr = '0;
  logic [7:0]  m0_req_len = '0,     m1_req_len = '0;
  logic        m0_req_ready, m1_req_ready;
  logic        m0_rsp_valid, m1_rsp_valid;
  logic [7:0]  m0_rsp_data, m1_rsp_data;
  logic        m0_rsp_last, m1_rsp_last;
  logic        m0_rsp_err, m1_rsp_err;
  logic [23:0] fr_addr;
  logic        fr_read_from_addr, fr_read_next;
  logic        fr_data_ready = 1'b0;
  logic [7:0]  fr_data = '0;

  always #5 clk = ~clk;

  flash_arbiter #(.LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .m0_req_valid(m0_req_valid), .m0_req_addr(m0_req_addr), .m0_req_len(m0_req_len),
    .m0_req_ready(m0_req_ready), .m0_rsp_valid(m0_rsp_valid), .m0_rsp_data(m0_rsp_data),
    .m0_rsp_last(m0_rsp_last), .m0_rsp_err(m0_rsp_err),
    .m1_req_valid(m1_req_valid), .m1_req_addr(m1_req_addr), .m1_req_len(m1_req_len),
    .m1_req_ready(m1_req_ready), .m1_rsp_valid(m1_rsp_valid), .m1_rsp_data(m1_rsp_data),
    .m1_rsp_last(m1_rsp_last), .m1_rsp_err(m1_rsp_err),
    .fr_addr(fr_addr), .fr_read_from_addr(fr_read_from_addr), .fr_read_next(fr_read_next),
    .fr_data_ready(fr_data_ready), .fr_data(fr_data)
  );

  logic [49:0] w_outs;
  assign w_outs = {m0_req_ready, m1_req_ready, m0_rsp_valid, m1_rsp_valid, m0_rsp_data,
                   m1_rsp_data, m0_rsp_last, m1_rsp_last, m0_rsp_err, m1_rsp_err,
                   fr_addr, fr_read_from_addr, fr_read_next};

  typedef struct packed {logic m; logic [7:0] d; logic last; logic err;} rsp_t;
  typedef struct packed {logic nxt; logic [23:0] a;} cmd_t;

  rsp_t rsp_q[$];
  cmd_t cmd_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_cmd_cyc = 0;
  int   last_cyc[2] = '{-1, -1};
  int   rc0, rc1;
  logic stall = 1'b0;

`ifdef FLASH_ARB_STREAM_EN
  localparam logic STREAM = 1'b1;
`else
  localparam logic STREAM = 1'b0;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural flash_reader: byte edge two cycles after each read pulse
  logic [23:0] fptr = '0;
  int          fdly = 0;
  initial forever begin
    @(posedge clk); #2;
    if (!rst) begin
      fdly = 0;
      fr_data_ready = 1'b0;
    end else if (fr_read_from_addr || fr_read_next) begin
      if (!stall) begin
        fptr = fr_read_from_addr ? fr_addr : fptr + 24'd1;
        fdly = 2;
        fr_data_ready = 1'b0;
      end
    end else if (fdly > 0) begin
      fdly--;
      if (fdly == 0) begin
        fr_data = fptr[7:0] ^ 8'hA5;
        fr_data_ready = 1'b1;
      end
    end
  end

  // Monitor: pops expected responses / flash commands as the DUT presents them
  rsp_t act, exp_r;
  cmd_t act_c, exp_c;
  logic [10:0] other;
  initial forever begin
    @(negedge clk);
    if (rst) begin
      if (fr_read_from_addr && fr_read_next) begin
        checks++; errors++;
        $display("FAIL both_read_pulses cyc=%0d", cyc);
      end
      if (m0_rsp_valid || m0_rsp_err || m1_rsp_valid || m1_rsp_err) begin
        act.m    = m1_rsp_valid | m1_rsp_err;
        act.d    = act.m ? m1_rsp_data : m0_rsp_data;
        act.last = act.m ? m1_rsp_last : m0_rsp_last;
        act.err  = act.m ? m1_rsp_err  : m0_rsp_err;
        other    = act.m ? {m0_rsp_valid, m0_rsp_data, m0_rsp_last, m0_rsp_err}
                         : {m1_rsp_valid, m1_rsp_data, m1_rsp_last, m1_rsp_err};
        checks++;
        if (rsp_q.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected cyc=%0d got m=%0d d=%h last=%b err=%b",
                   cyc, act.m, act.d, act.last, act.err);
        end else begin
          exp_r = rsp_q.pop_front();
          if (act !== exp_r || other !== '0) begin
            errors++;
            $display("FAIL rsp cyc=%0d got m=%0d d=%h last=%b err=%b other=%h expected m=%0d d=%h last=%b err=%b other=0",
                     cyc, act.m, act.d, act.last, act.err, other, exp_r.m, exp_r.d, exp_r.last, exp_r.err);
          end
        end
        if (act.err) begin
          checks++;
          if (cyc - last_cmd_cyc != TIMEOUT + 1) begin
            errors++;
            $display("FAIL wd_timing got %0d cycles after issue, expected %0d",
                     cyc - last_cmd_cyc, TIMEOUT + 1);
          end
        end
        if (act.last) last_cyc[act.m] = cyc;
      end
      if (fr_read_from_addr || fr_read_next) begin
        act_c = {fr_read_next, fr_addr};
        checks++;
        if (cmd_q.size() == 0) begin
          errors++;
          $display("FAIL cmd_unexpected cyc=%0d got next=%b addr=%h", cyc, act_c.nxt, act_c.a);
        end else begin
          exp_c = cmd_q.pop_front();
          if (act_c !== exp_c) begin
            errors++;
            $display("FAIL cmd cyc=%0d got next=%b addr=%h expected next=%b addr=%h",
                     cyc, act_c.nxt, act_c.a, exp_c.nxt, exp_c.a);
          end
        end
        last_cmd_cyc = cyc;
      end
    end
  end

  // Queue the flash commands and returned bytes a normal burst should produce
  task automatic exp_burst(input int m, input logic [23:0] a, input logic [7:0] l,
                           input logic first_next);
    logic [23:0] t;
    rsp_t        r;
    cmd_t        c;
    c.nxt = first_next; c.a = a;
    cmd_q.push_back(c);
    for (int i = 0; i <= int'(l); i++) begin
      if (i > 0) begin
        c.nxt = 1'b1; c.a = a;
        cmd_q.push_back(c);
      end
      t      = a + 24'(i);
      r.m    = m[0];
      r.d    = t[7:0] ^ 8'hA5;
      r.last = (i == int'(l));
      r.err  = 1'b0;
      rsp_q.push_back(r);
    end
  endtask

  // Post a request and hold it until accepted; returns the accept cycle
  task automatic post(input int m, input logic [23:0] a, input logic [7:0] l, output int rcyc);
    int n;
    @(posedge clk); #1;
    if (m == 0) begin m0_req_valid = 1'b1; m0_req_addr = a; m0_req_len = l; end
    else        begin m1_req_valid = 1'b1; m1_req_addr = a; m1_req_len = l; end
    for (n = 0; n < 300; n++) begin
      @(negedge clk);
      if ((m == 0) ? m0_req_ready : m1_req_ready) break;
    end
    rcyc = cyc;
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL req_ready_timeout m%0d addr=%h got no accept, expected accept", m, a);
    end
    @(posedge clk); #1;
    if (m == 0) m0_req_valid = 1'b0;
    else        m1_req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 400 && (rsp_q.size() != 0 || cmd_q.size() != 0); n++) @(negedge clk);
    checks++;
    if (rsp_q.size() != 0 || cmd_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout got %0d rsp/%0d cmd pending, expected 0/0",
               rsp_q.size(), cmd_q.size());
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    rsp_q.delete();
    cmd_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  rsp_t er;
  cmd_t ec;
  initial begin
    // Reset state, with a request pending to show accept is suppressed
    m0_req_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (w_outs !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %h expected 0", w_outs);
    end
    m0_req_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b1;

    // Single 4-byte burst from m0
    exp_burst(0, 24'h001000, 8'd3, 1'b0);
    post(0, 24'h001000, 8'd3, rc0);
    drain();

    // Tie from reset: m0 first, m1 accepted with m0's last byte
    do_reset();
    exp_burst(0, 24'h002000, 8'd1, 1'b0);
    exp_burst(1, 24'h003000, 8'd1, 1'b0);
    fork
      post(0, 24'h002000, 8'd1, rc0);
      post(1, 24'h003000, 8'd1, rc1);
    join
    drain();
    checks++;
    if (rc1 != last_cyc[0]) begin
      errors++;
      $display("FAIL m1_accept_cycle got %0d expected %0d", rc1, last_cyc[0]);
    end

    // m0 alone, then a tie: m1 must win first
    exp_burst(0, 24'h002100, 8'd0, 1'b0);
    post(0, 24'h002100, 8'd0, rc0);
    drain();
    exp_burst(1, 24'h003100, 8'd0, 1'b0);
    exp_burst(0, 24'h002200, 8'd0, 1'b0);
    fork
      post(0, 24'h002200, 8'd0, rc0);
      post(1, 24'h003100, 8'd0, rc1);
    join
    drain();

    // Contiguous follow-on burst
    exp_burst(0, 24'h000100, 8'd0, 1'b0);
    post(0, 24'h000100, 8'd0, rc0);
    drain();
    exp_burst(0, 24'h000101, 8'd1, STREAM);
    post(0, 24'h000101, 8'd1, rc0);
    drain();

    // Address wrap at the top of the 24-bit space
    exp_burst(1, 24'hFFFFFF, 8'd0, 1'b0);
    post(1, 24'hFFFFFF, 8'd0, rc1);
    drain();
    exp_burst(1, 24'h000000, 8'd0, STREAM);
    post(1, 24'h000000, 8'd0, rc1);
    drain();

    // Stalled flash: watchdog abort, recovery pulse, then normal service
    stall = 1'b1;
    ec.nxt = 1'b0; ec.a = 24'h004000;
    cmd_q.push_back(ec);
    er.m = 1'b0; er.d = 8'h00; er.last = 1'b0; er.err = 1'b1;
    rsp_q.push_back(er);
    cmd_q.push_back(ec);
    post(0, 24'h004000, 8'd0, rc0);
    drain();
    stall = 1'b0;
    exp_burst(0, 24'h005000, 8'd1, 1'b0);
    post(0, 24'h005000, 8'd1, rc0);
    drain();

    // Reset in the middle of a burst
    exp_burst(0, 24'h005002, 8'd3, STREAM);
    post(0, 24'h005002, 8'd3, rc0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++;
    if (w_outs !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs got %h expected 0", w_outs);
    end
    rsp_q.delete();
    cmd_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    exp_burst(0, 24'h005002, 8'd0, 1'b0);
    post(0, 24'h005002, 8'd0, rc0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got no completion, expected completion");
    $fatal(1, "bench time limit");
  end

endmodule
`default_nettype wire

// File: doc/flash_arbiter.md
# flash_arbiter

Shares the single `flash_reader` byte-stream port between two requesters: instruction fetch (master 0) and data load (master 1). Each master posts a burst read of 1..2^LEN_W bytes at a 24-bit flash address. The arbiter grants masters round-robin and sequences `flash_reader` through its `read_from_addr` / `read_next` / `data_ready` handshake. It returns bytes to the granted master with a last-byte flag, and has a watchdog against a stalled flash.

## Interface
- `LEN_W`, 8: width of burst length field; length encoded as bytes-1.
- `TIMEOUT`, 4096: max cycles waiting for a `data_ready` rising edge; 0 disables the watchdog.

- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous assert, active-low.
- `m0_req_valid`, `m1_req_valid`  in  1  request pending; held until accepted.
- `m0_req_addr`, `m1_req_addr`  in  24  start byte address.
- `m0_req_len`, `m1_req_len`  in  LEN_W  bytes-1.
- `m0_req_ready`, `m1_req_ready`  out  1  one-cycle accept pulse.
- `m0_rsp_valid`, `m1_rsp_valid`  out  1  one-cycle byte strobe; no backpressure.
- `m0_rsp_data`, `m1_rsp_data`  out  8  byte; valid only with `rsp_valid`.
- `m0_rsp_last`, `m1_rsp_last`  out  1  with final byte of burst.
- `m0_rsp_err`, `m1_rsp_err`  out  1  one-cycle pulse: burst aborted by watchdog.
- `fr_addr`  out  24  to `flash_reader.addr`.
- `fr_read_from_addr`  out  1  one-cycle pulse.
- `fr_read_next`  out  1  one-cycle pulse.
- `fr_data_ready`  in  1  from `flash_reader`; bytes are signalled by its rising edge.
- `fr_data`  in  8  from `flash_reader`.

## Operation
- States: IDLE, ISSUE, WAIT, NEXT.
- **IDLE**
  - If any `req_valid`, pick a winner: sole requester wins; if both request, the master not granted last wins.
  - Pulse the winner's `req_ready`, latch addr/len into `cur_addr`/`remaining`, record `grant` → ISSUE.
- **ISSUE**
  - Drive `fr_addr=cur_addr`.
  - Pulse `fr_read_from_addr`, or `fr_read_next` when stream continuation applies (see Configuration).
  - Clear the watchdog → WAIT.
- **WAIT**
  - Detect a rising edge: `fr_data_ready=1` and the registered previous value is 0.
  - On the edge, capture `fr_data`.
  - If `remaining==0`: set the next-cycle `rsp_valid` and `rsp_last` to the granted master, set `next_addr=cur_addr+len+1` (mod 2^24) and `stream_valid=1` → IDLE.
  - Otherwise: set the next-cycle `rsp_valid`, decrement `remaining` → NEXT.
- **NEXT**: pulse `fr_read_next`, clear the watchdog → WAIT.
- **Watchdog**
  - Counts cycles in WAIT.
  - On reaching TIMEOUT: pulse the granted master's `rsp_err`, clear `stream_valid`, pulse `fr_read_from_addr` with `fr_addr=cur_addr` to resynchronise the reader → IDLE.
  - No `rsp_last` on an abort.
- `fr_addr` holds `cur_addr` from ISSUE until the next grant.
- The non-granted master sees no `rsp_*` activity.
- Requests are not accepted outside IDLE. `req_valid` changes while waiting are legal.
- `fr_read_from_addr` and `fr_read_next` are never both high.

## Timing
- Reset: every output 0; state IDLE; `grant=1` (so m0 wins the first tie); `stream_valid=0`; counters 0.
- Reset asserted mid-burst aborts immediately with no `rsp_err`.
- `req_valid`=1 in IDLE at cycle T:
  - `req_ready` at T.
  - Read pulse at T+1.
- Rising edge of `fr_data_ready` sampled at cycle E:
  - `rsp_valid` at E+1.
  - `fr_read_next` at E+1 if bytes remain.
- Back-to-back: last byte at E gives IDLE at E+1, so a new `req_ready` can come at E+1 and its issue at E+2.
- A level-high `fr_data_ready` held across NEXT is not a new byte; only the 0→1 transition counts.

## Configuration
- `FLASH_ARB_STREAM_EN` defined: in ISSUE, if `stream_valid` and the latched address equals `next_addr`, issue `fr_read_next` instead of `fr_read_from_addr`. This skips the flash command/address phase.
- Undefined: ISSUE always pulses `fr_read_from_addr`; `next_addr`/`stream_valid` are not built.

## Structure
- Package `flash_arb_pkg`:
  - state enum `flash_arb_state_e`
  - `FLASH_ADDR_W=24`
  - master-id typedef
- Sub-module `flash_arb_rr`: 2-way round-robin picker.
  - Inputs: two valids, last grant.
  - Outputs: grant valid and id.

## Test plan
- m0 req addr 0x001000 len 3 alone → one `fr_read_from_addr` with `fr_addr=0x001000`, then 3 `fr_read_next`; 4 `m0_rsp_valid` bytes matching the model; `rsp_last` on the 4th.
- m0 and m1 request in the same cycle from reset → m0 granted first, m1 granted the cycle after m0's `rsp_last`. Repeat with both valid → m1 wins first next time.
- STREAM_EN: m0 0x000100 len 0, then m0 0x000101 len 1 → second burst starts with `fr_read_next`, no `fr_read_from_addr`. Without the macro, `fr_read_from_addr` is issued.
- Wrap: m1 0xFFFFFF len 0, then 0x000000 len 0 with STREAM_EN → second burst issues `fr_read_next`.
- TIMEOUT=16, `fr_data_ready` held 0 → `m0_rsp_err` pulse 16 cycles after entering WAIT, recovery `fr_read_from_addr`, next request served normally.
- Reset low during WAIT of a 4-byte burst → all outputs 0 immediately. After release, a new request restarts with `fr_read_from_addr` even at a contiguous address.
